// File: rtl/board_io_pkg.sv
// Shared types and default constants for the board input conditioner.
package board_io_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_t;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 400000;
  localparam int unsigned DEF_RST_HOLD_CYCLES = 16;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: synchroniser, stability counter and registered
// level / press / release outputs.
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Counter restarts whenever the synced input agrees with the accepted level.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (synced == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = ~level_q;
      press_d = ~level_q;
      rel_d   = level_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/board_io_conditioner.sv
// Board input front end: debounced buttons plus system reset sequencing
// from block reset, clock-wizard lock and a reset button.
module board_io_conditioner
  import board_io_pkg::*;
#(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int unsigned BTN_RST_IDX     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked_in,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             sys_rst_out
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  rst_state_t             state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                   sys_rst_q, sys_rst_d;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   locked_synced;
  logic                   dirty;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (btn_raw[g]),
      .level_o  (btn_level[g]),
      .press_o  (btn_press[g]),
      .release_o(btn_release[g])
    );
  end

  assign locked_synced = lock_sync_q[SYNC_STAGES-1];
  assign dirty         = rst | ~locked_synced | btn_level[BTN_RST_IDX];

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync_q <= '0;
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      sys_rst_q   <= 1'b1;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked_in};
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      sys_rst_q   <= sys_rst_d;
    end
  end

  // Any dirty cycle in HOLD restarts the full clean-hold period.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      HOLD: begin
        if (dirty) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      RUN: begin
        if (dirty) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = HOLD;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    sys_rst_d = (state_d == HOLD);
  end

  assign sys_rst_out = sys_rst_q;

endmodule
